uart_frame_tx: RTL
==================

# uart_frame_tx

Parametrised framed telemetry transmitter for the vision/servo UART link. On a frame trigger (typically the vsync rising edge) it snapshots `NUM_CH` channel words of `CH_W` bits and serialises them as one checksummed packet. Baud divisor, parity and stop-bit count are configurable. It replaces the fixed-format data generator and TX pair on the telemetry path, adds drop accounting for triggers that arrive while a frame is in flight, and feeds the board `uart_tx` pin.

## Interface
Parameters:
- `BPS_NUM`, 645: clock cycles per UART bit; legal range 2..65535.
- `NUM_CH`, 4: number of channel words per frame; legal range 1..31.
- `CH_W`, 43: width of each channel word; legal range 1..64.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk` input 1: single system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `en` input 1: trigger enable.
- `trigger` input 1: frame request level, synchronous to `clk`; the block detects its rising edge.
- `ch_data` input NUM_CH*CH_W: channel i occupies `[i*CH_W +: CH_W]`.
- `uart_tx` output 1: serial line, idle high.
- `busy` output 1: a frame is in flight.
- `frame_done` output 1: one-cycle pulse at frame end.
- `drop_cnt` output 8: saturating count of rejected triggers.

## Operation
- `BPC = ceil(CH_W/8)` bytes per channel.
- `LEN = NUM_CH*BPC`; `LEN` must be at most 255. The implementation checks this at elaboration.
- Each channel word is zero-extended to `BPC*8` bits and sent MSB byte first.
- Frame byte order:
  - `0xAA`, `0x55`
  - `LEN`
  - payload: channel 0 first, through channel NUM_CH-1
  - `CHK`
- `CHK` = (LEN + sum of all payload bytes) mod 256. The header bytes are excluded from the sum.
- Character format: start bit (0), 8 data bits LSB first, optional parity bit, then `STOP_BITS` stop bits (1).
  - Odd parity: data bits plus parity bit contain an odd number of ones.
  - Even parity: data bits plus parity bit contain an even number of ones.
- Accepted trigger: rising edge (`trigger`=1 this cycle, 0 the previous cycle) while `en`=1 and `busy`=0. The block snapshots all of `ch_data` into an internal register. Later changes to `ch_data` do not affect the frame.
- Rejected trigger: rising edge while `busy`=1. `drop_cnt` increments and saturates at 255. A rising edge while `en`=0 is ignored and not counted.
- `en` falling mid-frame does not abort the frame; the frame completes.
- Bit FSM states:
  - IDLE → START on an accepted trigger.
  - START → DATA after `BPS_NUM` cycles.
  - DATA → PARITY (if `PARITY`≠0) or STOP after 8 bits.
  - PARITY → STOP.
  - STOP → START (next byte) or IDLE (after `CHK`) after `STOP_BITS*BPS_NUM` cycles.
- A byte index counter from 0 to LEN+3 selects the byte source: header, LEN, snapshot byte, or the running checksum.
- The checksum accumulates as each byte is loaded. `CHK` is never recomputed from the snapshot.

## Timing
- Reset values: `uart_tx`=1, `busy`=0, `frame_done`=0, `drop_cnt`=0. The FSM goes to IDLE and the edge detector's previous-trigger register goes to 0.
- A reset assertion mid-frame drives the line high immediately and asynchronously. The frame is discarded.
- Trigger edge sampled at cycle T: snapshot is taken and `busy`=1 from T+1, and `uart_tx`=0 (start bit) from T+1.
- Each bit lasts exactly `BPS_NUM` cycles.
- Bytes are sent back-to-back with no idle gap between the stop bit and the next start bit.
- Character length `C = 10 + (PARITY?1:0) + (STOP_BITS-1)` bits.
- Frame length = `(LEN+4)*C*BPS_NUM` cycles, measured from T+1.
- In the last cycle of the final stop bit, `frame_done`=1. On the next cycle `busy`=0 and `frame_done`=0.
- A trigger edge in the first cycle with `busy`=0 is accepted, so the minimum inter-frame line idle is 1 cycle.
- A trigger edge in the `frame_done` cycle is rejected and counted.

## Test plan
- NUM_CH=2, CH_W=12, BPS_NUM=4, PARITY=0, STOP_BITS=1; ch0=0xABC, ch1=0x123; one trigger edge:
  - line decodes as AA 55 04 0A BC 01 23 EE;
  - `busy` lasts exactly 320 cycles;
  - `frame_done` pulses once.
- Same configuration, `ch_data` changed at T+5:
  - payload still 0A BC 01 23 and `CHK`=EE.
- Second trigger edge mid-frame, repeated 300 times across frames:
  - `drop_cnt` reaches 255 and holds;
  - the in-flight frame is unaffected.
- PARITY=2, STOP_BITS=2, ch0=0x007, ch1=0x000:
  - payload byte 0x07 carries parity 1, byte 0x00 carries parity 0;
  - each character is 12 bits;
  - `CHK` = 0x04+0x00+0x07 = 0x0B.
- `en`=0 with a trigger edge:
  - no frame sent and `drop_cnt` unchanged.
- `en` dropped mid-frame:
  - frame completes normally.
- `reset_n` pulsed low at byte 3, bit 4:
  - `uart_tx`=1 in the same cycle;
  - `busy`=0 and `drop_cnt`=0;
  - the next trigger produces a complete, correct frame.

Source files
------------

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: framed telemetry UART transmitter.
// On an accepted rising edge of trigger, snapshots NUM_CH channel words and sends
// AA 55 LEN payload CHK, where CHK = (LEN + sum of payload bytes) mod 256.
// Each channel is zero-extended to whole bytes and sent MSB byte first.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   en           : trigger enable (does not abort a frame in flight)
//   trigger      : frame request level; rising edge starts a frame
//   ch_data      : channel i at [i*CH_W +: CH_W]
//   uart_tx      : serial line, idle high
//   busy         : frame in flight
//   frame_done   : one-cycle pulse in the last cycle of the final stop bit
//   drop_cnt     : saturating count of triggers rejected while busy
module uart_frame_tx #(
   parameter int unsigned BPS_NUM   = 645,
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned CH_W      = 43,
   parameter int unsigned PARITY    = 0,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     en,
   input  logic                     trigger,
   input  logic [NUM_CH*CH_W-1:0]   ch_data,
   output logic                     uart_tx,
   output logic                     busy,
   output logic                     frame_done,
   output logic [7:0]               drop_cnt
);

   localparam int unsigned BPC      = (CH_W + 7) / 8;
   localparam int unsigned LEN      = NUM_CH * BPC;
   localparam int unsigned SNAP_W   = LEN * 8;
   localparam int unsigned STOP_LEN = STOP_BITS * BPS_NUM;

   localparam logic [16:0] BIT_LAST  = 17'(BPS_NUM - 1);
   localparam logic [16:0] STOP_LAST = 17'(STOP_LEN - 1);
   localparam logic [16:0] STOP_PRE  = 17'(STOP_LEN - 2);
   localparam logic [8:0]  IDX_CHK   = 9'(LEN + 3);
   localparam logic [7:0]  LEN_B     = 8'(LEN);

   if (LEN > 255) begin : gen_len_chk
      $error("uart_frame_tx: NUM_CH*ceil(CH_W/8) must not exceed 255");
   end
   if (PARITY > 2) begin : gen_par_chk
      $error("uart_frame_tx: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_stop_chk
      $error("uart_frame_tx: STOP_BITS must be 1 or 2");
   end

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   state_e              st_q;
   logic                trig_q;
   logic                tx_q;
   logic                busy_q;
   logic                frame_done_q;
   logic [7:0]          drop_q;
   logic [16:0]         cnt_q;
   logic [2:0]          bit_idx_q;
   logic [8:0]          byte_idx_q;
   logic [7:0]          sh_q;
   logic                par_q;
   logic [7:0]          chk_q;
   logic [SNAP_W-1:0]   snap_q;
   logic [SNAP_W-1:0]   snap_d;

   logic                rise;
   logic                accept;
   logic                reject;
   logic [8:0]          ld_idx;
   logic                ld_payload;
   logic [7:0]          ld_byte;

   function automatic logic par_of(input logic [7:0] b);
      return (PARITY == 1) ? ~^b : ^b;
   endfunction

   assign rise   = trigger & ~trig_q;
   assign accept = rise & en & ~busy_q;
   assign reject = rise & en & busy_q;

   // Payload in transmit order, payload byte k at [k*8 +: 8], so the frame can
   // be emitted by shifting the snapshot right one byte at a time.
   always_comb begin
      logic [BPC*8-1:0] word;
      snap_d = '0;
      word   = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         word           = '0;
         word[CH_W-1:0] = ch_data[c*CH_W +: CH_W];
         for (int unsigned b = 0; b < BPC; b++) begin
            snap_d[(c*BPC + b)*8 +: 8] = word[(BPC-1-b)*8 +: 8];
         end
      end
   end

   // Source of the byte loaded at the end of the current stop period.
   always_comb begin
      ld_idx     = byte_idx_q + 9'd1;
      ld_payload = (ld_idx >= 9'd3) && (ld_idx < IDX_CHK);
      if (ld_idx == 9'd1) begin
         ld_byte = 8'h55;
      end else if (ld_idx == 9'd2) begin
         ld_byte = LEN_B;
      end else if (ld_payload) begin
         ld_byte = snap_q[7:0];
      end else begin
         ld_byte = chk_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_q         <= StIdle;
         trig_q       <= 1'b0;
         tx_q         <= 1'b1;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         drop_q       <= 8'd0;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         byte_idx_q   <= '0;
         sh_q         <= '0;
         par_q        <= 1'b0;
         chk_q        <= '0;
         snap_q       <= '0;
      end else begin
         trig_q       <= trigger;
         frame_done_q <= 1'b0;
         cnt_q        <= cnt_q + 17'd1;
         if (reject && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
         end
         case (st_q)
            StIdle: begin
               cnt_q <= '0;
               if (accept) begin
                  st_q       <= StStart;
                  tx_q       <= 1'b0;
                  busy_q     <= 1'b1;
                  snap_q     <= snap_d;
                  sh_q       <= 8'hAA;
                  par_q      <= par_of(8'hAA);
                  chk_q      <= '0;
                  byte_idx_q <= '0;
               end
            end
            StStart: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q     <= '0;
                  st_q      <= StData;
                  tx_q      <= sh_q[0];
                  bit_idx_q <= '0;
               end
            end
            StData: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q <= '0;
                  if (bit_idx_q == 3'd7) begin
                     if (PARITY != 0) begin
                        st_q <= StParity;
                        tx_q <= par_q;
                     end else begin
                        st_q <= StStop;
                        tx_q <= 1'b1;
                     end
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                     sh_q      <= sh_q >> 1;
                     tx_q      <= sh_q[1];
                  end
               end
            end
            StParity: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q <= '0;
                  st_q  <= StStop;
                  tx_q  <= 1'b1;
               end
            end
            StStop: begin
               // Registered pulse: set one cycle early so it lands on the last cycle.
               if (byte_idx_q == IDX_CHK && cnt_q == STOP_PRE) begin
                  frame_done_q <= 1'b1;
               end
               if (cnt_q == STOP_LAST) begin
                  cnt_q <= '0;
                  if (byte_idx_q == IDX_CHK) begin
                     st_q   <= StIdle;
                     busy_q <= 1'b0;
                  end else begin
                     st_q       <= StStart;
                     tx_q       <= 1'b0;
                     byte_idx_q <= ld_idx;
                     sh_q       <= ld_byte;
                     par_q      <= par_of(ld_byte);
                     if (ld_payload) begin
                        snap_q <= snap_q >> 8;
                     end
                     // Header bytes are excluded; LEN and payload are summed.
                     if (ld_payload || ld_idx == 9'd2) begin
                        chk_q <= chk_q + ld_byte;
                     end
                  end
               end
            end
            default: st_q <= StIdle;
         endcase
      end
   end

   assign uart_tx    = tx_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign drop_cnt   = drop_q;

endmodule
